alu_cmd_driver: RTL and testbench
=================================

Name: alu_cmd_driver

Overview:
- Sequential initiator for the combinational alu_32bit: buffers ALU commands (a, b, op, cin) in a small FIFO and issues them one at a time to the ALU.
- Holds each command's ALU inputs stable for a programmable settle window, then captures R/cout/S/V into a response register.
- Returns the captured result through a valid/ready response port.
- Sits between a requester (datapath control or bench) and alu_32bit; the ALU is instantiated outside this block.

Parameters:
- DEPTH, 4: command FIFO entries; power of two, >= 2.
- PTRW, 2: log2(DEPTH); FIFO pointer width.
- SETTLE, 2: cycles the ALU inputs are held before capture; >= 1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  FIFO can accept; equals (cmd_count < DEPTH).
- cmd_a  input  32  operand A.
- cmd_b  input  32  operand B.
- cmd_op  input  3  ALU op code, passed to the ALU unchanged (3'b100 = SLT).
- cmd_cin  input  1  carry-in.
- alu_a / alu_b  output  32  registered ALU operands.
- alu_op  output  3  registered ALU op.
- alu_cin  output  1  registered carry-in.
- alu_r  input  32  ALU result.
- alu_cout / alu_s / alu_v  input  1  ALU carry, sign, overflow.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  response consumed.
- rsp_r  output  32  captured result.
- rsp_op  output  3  op of the captured command.
- rsp_cout / rsp_s / rsp_v  output  1  captured flags.
- busy  output  1  high in WAIT or RESP.
- cmd_count  output  PTRW+1  FIFO occupancy.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - All outputs 0 except cmd_ready=1.
  - FIFO emptied; state=IDLE; settle counter=0.
  - Any in-flight or pending response is discarded.
- FIFO:
  - Push on cmd_valid && cmd_ready.
  - Pop only on the IDLE->WAIT transition.
  - Push and pop in the same cycle leave the count unchanged.
  - No pass-through: a command takes at least one cycle in the FIFO.
  - When full, cmd_ready=0 and cmd_valid is ignored.
  - Pointers wrap modulo DEPTH.
- State IDLE:
  - If cmd_count>0 at the edge: pop head, load alu_* with it, load counter=SETTLE-1, go to WAIT.
  - Otherwise stay in IDLE.
- State WAIT:
  - If counter != 0: decrement.
  - If counter == 0: sample alu_r/cout/s/v into rsp_*, copy alu_op into rsp_op, set rsp_valid=1, go to RESP.
- State RESP:
  - rsp_* and rsp_valid are held stable while rsp_ready=0.
  - On rsp_valid && rsp_ready: clear rsp_valid and go to IDLE.
  - The next command issues at the following edge, so back-to-back issue spacing is SETTLE+2 cycles.
- alu_* outputs keep the last issued command until the next issue; they are never zeroed except by reset.
- Latency: command accepted at edge E into an empty, idle block gives rsp_valid=1 after edge E+SETTLE+1.
- cmd_valid/cmd_ready may toggle freely during WAIT/RESP; commands queue up to DEPTH.
- Response order equals command order; no command is dropped or duplicated.
- Op codes are not decoded; undefined codes are issued and captured like any other.
- Flag semantics are entirely the ALU's.

Test Plan:
- Single SLT: a=32'h0000000B, b=32'h000FF005, op=3'b100, cin=0 accepted at edge E.
  - rsp_valid rises after edge E+3 (SETTLE=2).
  - rsp_r=32'h00000001, rsp_op=3'b100.
  - alu_a/alu_b hold the operands from edge E+1 through capture.
- SLT false case: a=32'h38404F07, b=32'h03003101, op=3'b100 -> rsp_r=32'h00000000.
- Burst of 5 commands with rsp_ready=1:
  - cmd_ready drops to 0 when cmd_count=4.
  - Responses return in order, each SETTLE+2 cycles apart.
  - cmd_count returns to 0 at the end.
- Backpressure: rsp_ready=0 for 10 cycles after rsp_valid.
  - rsp_r/flags stay constant and no new issue occurs (alu_* unchanged).
  - Raising rsp_ready completes the handshake in 1 cycle.
- Simultaneous push/pop with FIFO at 2 entries: count stays 2; wrap-around is exercised by 8 sequential commands.
- Reset mid-operation: assert rst_n=0 during WAIT with 3 queued commands.
  - All outputs 0 immediately; cmd_ready=1; cmd_count=0.
  - No stale response appears after release.

Source files
------------

// File: rtl/alu_cmd_driver.sv
// alu_cmd_driver: queues ALU commands in a FIFO, issues one at a time to an external ALU,
// holds operands for a settle window, then returns the captured result via valid/ready.
module alu_cmd_driver #(
    parameter int DEPTH  = 4,
    parameter int PTRW   = 2,
    parameter int SETTLE = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [31:0]     cmd_a,
    input  logic [31:0]     cmd_b,
    input  logic [2:0]      cmd_op,
    input  logic            cmd_cin,
    output logic [31:0]     alu_a,
    output logic [31:0]     alu_b,
    output logic [2:0]      alu_op,
    output logic            alu_cin,
    input  logic [31:0]     alu_r,
    input  logic            alu_cout,
    input  logic            alu_s,
    input  logic            alu_v,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [31:0]     rsp_r,
    output logic [2:0]      rsp_op,
    output logic            rsp_cout,
    output logic            rsp_s,
    output logic            rsp_v,
    output logic            busy,
    output logic [PTRW:0]   cmd_count
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    localparam int CW = $clog2(SETTLE) + 1;
    state_t          state;
    logic [CW-1:0]   cnt;
    logic [31:0]     mem_a [DEPTH];
    logic [31:0]     mem_b [DEPTH];
    logic [2:0]      mem_op [DEPTH];
    logic            mem_cin [DEPTH];
    logic [PTRW-1:0] wr_ptr, rd_ptr;
    logic            push, pop;
    assign cmd_ready = cmd_count < (PTRW+1)'(DEPTH);
    assign push      = cmd_valid && cmd_ready;
    // pop looks at the registered count, so a command pushed this cycle cannot bypass the FIFO
    assign pop       = (state == IDLE) && (cmd_count != '0);
    assign busy      = state != IDLE;
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr]   <= cmd_a;
            mem_b[wr_ptr]   <= cmd_b;
            mem_op[wr_ptr]  <= cmd_op;
            mem_cin[wr_ptr] <= cmd_cin;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cmd_count <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            alu_cin   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_r     <= '0;
            rsp_op    <= '0;
            rsp_cout  <= 1'b0;
            rsp_s     <= 1'b0;
            rsp_v     <= 1'b0;
        end else begin
            wr_ptr    <= push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr    <= pop ? rd_ptr + 1'b1 : rd_ptr;
            cmd_count <= cmd_count + (PTRW+1)'(push) - (PTRW+1)'(pop);
            case (state)
                IDLE: if (pop) begin
                    alu_a   <= mem_a[rd_ptr];
                    alu_b   <= mem_b[rd_ptr];
                    alu_op  <= mem_op[rd_ptr];
                    alu_cin <= mem_cin[rd_ptr];
                    cnt     <= CW'(SETTLE - 1);
                    state   <= WAIT;
                end
                WAIT: if (cnt != '0) begin
                    cnt <= cnt - 1'b1;
                end else begin
                    rsp_r     <= alu_r;
                    rsp_op    <= alu_op;
                    rsp_cout  <= alu_cout;
                    rsp_s     <= alu_s;
                    rsp_v     <= alu_v;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_cmd_driver.sv
// tb_alu_cmd_driver: scoreboard bench with a behavioural ALU closing the loop around the driver.
module tb_alu_cmd_driver;
    localparam int SETTLE = 2;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_cin;
    logic [31:0] cmd_a, cmd_b;
    logic [2:0]  cmd_op;
    logic [31:0] alu_a, alu_b, alu_r;
    logic [2:0]  alu_op;
    logic        alu_cin, alu_cout, alu_s, alu_v;
    logic        rsp_valid, rsp_ready, rsp_cout, rsp_s, rsp_v, busy;
    logic [31:0] rsp_r;
    logic [2:0]  rsp_op;
    logic [2:0]  cmd_count;
    int          n_err = 0;
    int          n_chk = 0;
    int          cyc = 0;
    int          last_hs = 0;
    bit          have_last = 0;
    bit          gap_on = 0;
    bit          seen_full;
    logic [37:0] sb[$];
    logic [37:0] sb_e;
    always #5 clk = ~clk;
    alu_cmd_driver #(.DEPTH(4), .PTRW(2), .SETTLE(SETTLE)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_cin(cmd_cin),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_cin(alu_cin),
        .alu_r(alu_r), .alu_cout(alu_cout), .alu_s(alu_s), .alu_v(alu_v),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_r(rsp_r), .rsp_op(rsp_op), .rsp_cout(rsp_cout), .rsp_s(rsp_s), .rsp_v(rsp_v),
        .busy(busy), .cmd_count(cmd_count)
    );
    // returns {cout, s, v, r}
    function automatic logic [34:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op, input logic cin);
        logic [32:0] t;
        logic        v;
        t = '0;
        v = 1'b0;
        case (op)
            3'b000: begin
                t = {1'b0, a} + {1'b0, b} + {32'b0, cin};
                v = (a[31] == b[31]) && (t[31] != a[31]);
            end
            3'b001: begin
                t = {1'b0, a} + {1'b0, ~b} + 33'd1;
                v = (a[31] != b[31]) && (t[31] != a[31]);
            end
            3'b010:  t = {1'b0, a & b};
            3'b011:  t = {1'b0, a | b};
            3'b100:  t = {32'b0, $signed(a) < $signed(b)};
            3'b101:  t = {1'b0, a ^ b};
            3'b110:  t = {1'b0, a << b[4:0]};
            default: t = {1'b0, a >> b[4:0]};
        endcase
        return {t[32], t[31], v, t[31:0]};
    endfunction
    always_comb {alu_cout, alu_s, alu_v, alu_r} = alu_f(alu_a, alu_b, alu_op, alu_cin);
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (rst_n) begin
            chk("ready", cmd_ready, cmd_count < 3'd4);
            if (cmd_valid && cmd_ready) sb.push_back({cmd_op, alu_f(cmd_a, cmd_b, cmd_op, cmd_cin)});
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) chk("sb_underflow", 1, 0);
                else begin
                    sb_e = sb.pop_front();
                    chk("rsp_r", rsp_r, sb_e[31:0]);
                    chk("rsp_op", rsp_op, sb_e[37:35]);
                    chk("rsp_flags", {rsp_cout, rsp_s, rsp_v}, sb_e[34:32]);
                end
                if (gap_on && have_last) chk("gap", cyc - last_hs, SETTLE + 2);
                last_hs   = cyc;
                have_last = 1;
            end
        end
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op, input logic cin);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_a = a;
        cmd_b = b;
        cmd_op = op;
        cmd_cin = cin;
        while (!cmd_ready && n < 100) begin
            tick();
            n++;
        end
        if (!cmd_ready) chk("send_timeout", 1, 0);
        tick();
        cmd_valid = 1'b0;
    endtask
    task automatic wait_rsp();
        int n = 0;
        while (!rsp_valid && n < 50) begin
            tick();
            n++;
        end
        chk("rsp_timeout", rsp_valid, 1);
    endtask
    task automatic wait_idle();
        int n = 0;
        while ((busy || rsp_valid || cmd_count != 0) && n < 200) begin
            tick();
            n++;
        end
        chk("idle_timeout", {busy, rsp_valid, cmd_count}, 0);
        chk("sb_empty", sb.size(), 0);
    endtask
    task automatic check_reset();
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_rsp_r", rsp_r, 0);
        chk("rst_misc", {alu_op, alu_cin, rsp_op, rsp_cout, rsp_s, rsp_v, rsp_valid, busy, cmd_count}, 0);
        chk("rst_ready", cmd_ready, 1);
    endtask
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal;
    end
    initial begin
        rst_n = 1'b1;
        cmd_valid = 1'b0;
        cmd_a = '0;
        cmd_b = '0;
        cmd_op = '0;
        cmd_cin = 1'b0;
        rsp_ready = 1'b0;
        #1 rst_n = 1'b0;
        #2 check_reset();
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        tick();
        // single SLT true with cycle-accurate latency
        rsp_ready = 1'b1;
        cmd_valid = 1'b1;
        cmd_a = 32'h0000000B;
        cmd_b = 32'h000FF005;
        cmd_op = 3'b100;
        cmd_cin = 1'b0;
        tick();
        cmd_valid = 1'b0;
        chk("e0_count", cmd_count, 1);
        chk("e0_valid", rsp_valid, 0);
        tick();
        chk("e1_alu_a", alu_a, 32'h0000000B);
        chk("e1_alu_b", alu_b, 32'h000FF005);
        chk("e1_busy", busy, 1);
        chk("e1_count", cmd_count, 0);
        tick();
        chk("e2_valid", rsp_valid, 0);
        chk("e2_alu_a", alu_a, 32'h0000000B);
        chk("e2_alu_b", alu_b, 32'h000FF005);
        tick();
        chk("e3_valid", rsp_valid, 1);
        chk("e3_rsp_r", rsp_r, 32'h00000001);
        chk("e3_rsp_op", rsp_op, 3'b100);
        chk("e3_alu_a", alu_a, 32'h0000000B);
        wait_idle();
        // SLT false
        send(32'h38404F07, 32'h03003101, 3'b100, 1'b0);
        wait_rsp();
        chk("slt0", rsp_r, 32'h00000000);
        wait_idle();
        // burst of 5, responses every SETTLE+2 cycles
        have_last = 0;
        gap_on = 1;
        seen_full = 0;
        for (int i = 0; i < 5; i++) begin
            send(32'h1000_0000 * i + 32'h55, 32'h0F0F_0000 + i, 3'(i), i[0]);
            if (cmd_count == 3'd4) begin
                seen_full = 1;
                chk("full_ready", cmd_ready, 0);
            end
        end
        chk("burst_full", seen_full, 1);
        wait_idle();
        gap_on = 0;
        chk("burst_count", cmd_count, 0);
        // backpressure: overflow add held for 10 cycles
        rsp_ready = 1'b0;
        send(32'h7FFFFFFF, 32'h00000001, 3'b000, 1'b0);
        send(32'hFFFF0000, 32'h0000FFFF, 3'b011, 1'b0);
        wait_rsp();
        for (int i = 0; i < 10; i++) begin
            chk("bp_rsp_r", rsp_r, 32'h80000000);
            chk("bp_flags", {rsp_cout, rsp_s, rsp_v, rsp_valid}, 4'b0111);
            chk("bp_alu_a", alu_a, 32'h7FFFFFFF);
            chk("bp_count", cmd_count, 1);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        chk("bp_release", rsp_valid, 0);
        wait_idle();
        // simultaneous push/pop at two entries, then wrap-around
        rsp_ready = 1'b0;
        send(32'h00000003, 32'h00000005, 3'b001, 1'b0);
        wait_rsp();
        send(32'hA5A5A5A5, 32'h0F0F0F0F, 3'b010, 1'b0);
        send(32'h80000000, 32'h80000000, 3'b000, 1'b1);
        chk("pp_pre", cmd_count, 2);
        rsp_ready = 1'b1;
        tick();
        chk("pp_idle", {busy, rsp_valid}, 0);
        cmd_valid = 1'b1;
        cmd_a = 32'hFFFFFFFF;
        cmd_b = 32'h00000001;
        cmd_op = 3'b110;
        tick();
        cmd_valid = 1'b0;
        chk("pp_count", cmd_count, 2);
        chk("pp_busy", busy, 1);
        for (int i = 0; i < 4; i++) send(32'hDEAD0000 + i, 32'h00000004 + i, 3'(i + 4), 1'b0);
        wait_idle();
        // reset during WAIT with three queued
        rsp_ready = 1'b0;
        send(32'h00000010, 32'h00000020, 3'b000, 1'b0);
        wait_rsp();
        for (int i = 0; i < 4; i++) send(32'h00000100 + i, 32'h00000001, 3'b001, 1'b1);
        chk("rs_full", cmd_ready, 0);
        rsp_ready = 1'b1;
        tick();
        tick();
        chk("rs_wait", {busy, rsp_valid, cmd_count}, 5'b10011);
        rst_n = 1'b0;
        #1 check_reset();
        sb.delete();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        tick();
        for (int i = 0; i < 12; i++) begin
            chk("stale", {rsp_valid, busy, cmd_count}, 0);
            tick();
        end
        send(32'hFFFFFFFF, 32'h00000001, 3'b100, 1'b0);
        wait_rsp();
        chk("post_slt", rsp_r, 32'h00000001);
        wait_idle();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
